// File: rtl/prefix_pkg.sv
// prefix_pkg: shared generate/propagate type and prefix helpers for the carry-propagate adder
package prefix_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    function automatic int prefix_levels(input int width);
        return $clog2(width);
    endfunction

    // Merge a higher group with the adjacent lower group into one spanning group
    function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
        return '{g: hi.g | (hi.p & lo.g), p: hi.p & lo.p};
    endfunction

endpackage

// File: rtl/pg_level.sv
// pg_level: one Kogge-Stone prefix level at span DIST, optionally registered
module pg_level
    import prefix_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIST  = 1,
    parameter bit PIPE  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv,
    input  logic              in_valid,
    input  pg_t  [WIDTH-1:0]  in_pg,
    input  logic [WIDTH-1:0]  in_raw,
    input  logic              in_cin,
    output logic              out_valid,
    output pg_t  [WIDTH-1:0]  out_pg,
    output logic [WIDTH-1:0]  out_raw,
    output logic              out_cin
);

    pg_t [WIDTH-1:0] nxt;

    // Bits below DIST already span down to bit 0 and pass through
    always_comb
        for (int i = 0; i < WIDTH; i++)
            nxt[i] = i >= DIST ? pg_combine(in_pg[i], in_pg[i >= DIST ? i - DIST : 0]) : in_pg[i];

    if (PIPE) begin : g_reg
        // Stage register; bubbles move along with real beats whenever the pipe advances
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                out_valid <= 1'b0;
                out_pg    <= '0;
                out_raw   <= '0;
                out_cin   <= 1'b0;
            end else if (adv) begin
                out_valid <= in_valid;
                out_pg    <= nxt;
                out_raw   <= in_raw;
                out_cin   <= in_cin;
            end
    end else begin : g_comb
        assign out_valid = in_valid;
        assign out_pg    = nxt;
        assign out_raw   = in_raw;
        assign out_cin   = in_cin;
    end

endmodule

// File: rtl/cpa_prefix_adder.sv
// cpa_prefix_adder: Kogge-Stone final adder with valid/ready handshake and optional per-level pipelining
module cpa_prefix_adder
    import prefix_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter bit PIPE  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  sum,
    output logic              cout
);

    localparam int LEVELS = prefix_levels(WIDTH);

    logic              adv;
    logic [WIDTH-1:0]  raw;
    pg_t  [WIDTH-1:0]  pre_pg;
    logic              s0_valid;
    pg_t  [WIDTH-1:0]  s0_pg;
    logic [WIDTH-1:0]  s0_raw;
    logic              s0_cin;
    logic              st_valid [LEVELS+1];
    pg_t  [WIDTH-1:0]  st_pg    [LEVELS+1];
    logic [WIDTH-1:0]  st_raw   [LEVELS+1];
    logic              st_cin   [LEVELS+1];
    logic [WIDTH-1:0]  carry;

    // The whole pipe moves together; it only stalls when a finished result is waiting
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    // Per-bit generate/propagate, with carry-in folded into bit 0 as a generate
    always_comb begin
        raw = a ^ b;
        for (int i = 0; i < WIDTH; i++)
            pre_pg[i] = '{g: a[i] & b[i], p: raw[i]};
        pre_pg[0].g = pre_pg[0].g | (raw[0] & cin);
    end

    if (PIPE) begin : g_pre_reg
        // Precompute register; raw propagate and cin ride along for the final sum
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                s0_valid <= 1'b0;
                s0_pg    <= '0;
                s0_raw   <= '0;
                s0_cin   <= 1'b0;
            end else if (adv) begin
                s0_valid <= in_valid;
                s0_pg    <= pre_pg;
                s0_raw   <= raw;
                s0_cin   <= cin;
            end
    end else begin : g_pre_comb
        assign s0_valid = in_valid;
        assign s0_pg    = pre_pg;
        assign s0_raw   = raw;
        assign s0_cin   = cin;
    end

    assign st_valid[0] = s0_valid;
    assign st_pg[0]    = s0_pg;
    assign st_raw[0]   = s0_raw;
    assign st_cin[0]   = s0_cin;

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        pg_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << k),
            .PIPE  (PIPE)
        ) u_level (
            .clk       (clk),
            .rst_n     (rst_n),
            .adv       (adv),
            .in_valid  (st_valid[k]),
            .in_pg     (st_pg[k]),
            .in_raw    (st_raw[k]),
            .in_cin    (st_cin[k]),
            .out_valid (st_valid[k+1]),
            .out_pg    (st_pg[k+1]),
            .out_raw   (st_raw[k+1]),
            .out_cin   (st_cin[k+1])
        );
    end

    // Carry into bit i is the group generate of bits i-1..0, or cin for bit 0
    always_comb begin
        carry[0] = st_cin[LEVELS];
        for (int i = 1; i < WIDTH; i++)
            carry[i] = st_pg[LEVELS][i-1].g;
    end

    // Output register holds the result steady while the consumer stalls
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else if (adv) begin
            out_valid <= st_valid[LEVELS];
            sum       <= st_raw[LEVELS] ^ carry;
            cout      <= st_pg[LEVELS][WIDTH-1].g;
        end

endmodule

// File: tb/tb_cpa_prefix_adder.sv
// tb_cpa_prefix_adder: randomized scoreboard bench for pipelined and combinational builds
module tb_cpa_prefix_adder;

    localparam int W = 16;

    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, cin = 1'b0, out_ready = 1'b0, sel = 1'b1;
    logic [W-1:0] a = '0, b = '0;
    logic ir_p, ov_p, co_p, ir_c, ov_c, co_c;
    logic [W-1:0] s_p, s_c;
    logic ir, ov, co;
    logic [W-1:0] s;
    int checks = 0, errors = 0, cyc = 0, stalls = 0, lat = 6, acc_cnt = 0;

    typedef struct {
        logic [W:0] res;
        int acc;
        int st;
        bit seen;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    assign ir = sel ? ir_p : ir_c;
    assign ov = sel ? ov_p : ov_c;
    assign co = sel ? co_p : co_c;
    assign s  = sel ? s_p  : s_c;

    cpa_prefix_adder #(.WIDTH(W), .PIPE(1)) u_pipe (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_p), .a(a), .b(b), .cin(cin),
        .out_valid(ov_p), .out_ready(out_ready), .sum(s_p), .cout(co_p)
    );

    cpa_prefix_adder #(.WIDTH(W), .PIPE(0)) u_comb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_c), .a(a), .b(b), .cin(cin),
        .out_valid(ov_c), .out_ready(out_ready), .sum(s_c), .cout(co_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One cycle: drive at negedge, observe settled outputs, update the scoreboard
    task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input logic ordy);
        @(negedge clk);
        in_valid = iv; a = ia; b = ib; cin = ic; out_ready = ordy;
        #1;
        check("in_ready", 32'(ir), 32'(!ov || ordy));
        if (ov && q.size() == 0)
            check("spurious_valid", 32'(ov), 32'(0));
        else if (ov) begin
            check("result", 32'({co, s}), 32'(q[0].res));
            if (!q[0].seen) begin
                check("latency", cyc, q[0].acc + lat + stalls - q[0].st);
                q[0].seen = 1'b1;
            end
            if (ordy) void'(q.pop_front());
        end
        if (iv && (!ov || ordy)) begin
            q.push_back('{res: {1'b0, ia} + {1'b0, ib} + (W+1)'(ic), acc: cyc, st: stalls, seen: 1'b0});
            acc_cnt++;
        end
        if (ov && !ordy) stalls++;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n = 1'b0; in_valid = 1'b1; a = W'($urandom); b = W'($urandom); out_ready = i[0];
            #1;
            check("rst_out_valid", 32'(ov), 32'(0));
            check("rst_sum", 32'(s), 32'(0));
            check("rst_cout", 32'(co), 32'(0));
            check("rst_in_ready", 32'(ir), 32'(1));
        end
        q.delete();
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
        check("drain_empty", q.size(), 0);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic random_run(input int beats);
        int start;
        start = acc_cnt;
        for (int i = 0; i < 3000 && acc_cnt - start < beats; i++)
            cycle(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0);
        check("random_beats", acc_cnt - start, beats);
        drain();
    endtask

    initial begin
        // Pipelined build
        sel = 1'b1; lat = 6;
        do_reset(3);
        cycle(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        cycle(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1);
        cycle(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
        drain();
        // Back-to-back beats, then a 3-cycle stall on the first result
        cycle(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b1);
        cycle(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1);
        cycle(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
        drain();
        // Reset with beats in flight and a result on the output
        for (int i = 0; i < 8; i++) cycle(1'b1, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        check("pre_reset_valid", 32'(ov), 32'(1));
        do_reset(1);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
        random_run(300);
        // Combinational build
        sel = 1'b0; lat = 1;
        do_reset(2);
        cycle(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        cycle(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        cycle(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1);
        drain();
        random_run(200);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
